serial_subtractor_32: RTL and testbench



---
 rtl/serial_subtractor_32_if.sv | 16 +
 rtl/serial_subtractor_32.sv | 66 ++++++
 tb/tb_serial_subtractor_32.sv | 136 +++++++++++++
 3 files changed

// File: rtl/serial_subtractor_32_if.sv
// serial_subtractor_32_if: operand/result handshake bundle for the digit-serial subtractor
interface serial_subtractor_32_if #(
  parameter int WIDTH = 32
);
  logic in_valid, in_ready, bin;
  logic out_valid, out_ready, bout, zero, ltu, lts;
  logic [WIDTH-1:0] a, b, diff;
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ltu, lts
  );
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ltu, lts
  );
endinterface

// File: rtl/serial_subtractor_32.sv
// serial_subtractor_32: digit-serial a - b - bin with borrow and signed/unsigned compare flags
module serial_subtractor_32 #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input logic clk,
  input logic reset,
  serial_subtractor_32_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = $clog2(STEPS + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr;
  logic [CW-1:0] cnt;
  logic [DIGIT:0] step;
  logic borrow, a_msb, b_msb, last, done, ovf;
  assign step = {1'b0, a_sr[DIGIT-1:0]} - {1'b0, b_sr[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow};
  assign last = cnt == CW'(STEPS - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.in_valid) state_nx = RUN;
      RUN: if (last) state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // digits leave A/B at the bottom and enter the result at the top, so after STEPS shifts diff is aligned
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      cnt <= '0;
      borrow <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      a_sr <= bus.a;
      b_sr <= bus.b;
      borrow <= bus.bin;
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
      cnt <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> DIGIT;
      b_sr <= b_sr >> DIGIT;
      d_sr <= (d_sr >> DIGIT) | (WIDTH'(step[DIGIT-1:0]) << (WIDTH - DIGIT));
      borrow <= step[DIGIT];
      cnt <= cnt + 1'b1;
    end
  // flags are forced low outside DONE so the reset view is all zeros
  assign done = state == DONE;
  assign ovf = (a_msb != b_msb) && (d_sr[WIDTH-1] != a_msb);
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = done;
  assign bus.diff = d_sr;
  assign bus.bout = done & borrow;
  assign bus.ltu = done & borrow;
  assign bus.zero = done & ~|d_sr;
  assign bus.lts = done & (d_sr[WIDTH-1] ^ ovf);
endmodule

// File: tb/tb_serial_subtractor_32.sv
// tb_serial_subtractor_32: directed and random checks of the serial subtractor against an arithmetic model
module tb_serial_subtractor_32;
  parameter int DIGIT = 1;
  localparam int STEPS = 32 / DIGIT;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t_acc = 0;
  serial_subtractor_32_if #(.WIDTH(32)) bus ();
  serial_subtractor_32 #(.WIDTH(32), .DIGIT(DIGIT)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bin, input int hold,
                       output logic [31:0] got);
    longint su, ss;
    logic [31:0] ed;
    logic eb, el;
    int lat;
    su = longint'({32'b0, a}) - longint'({32'b0, b}) - longint'(bin);
    ss = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    ed = su[31:0];
    eb = su < 0;
    el = ss < 0;
    lat = 0;
    while (!bus.in_ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("in_ready_idle", 32'(bus.in_ready), 1);
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    bus.in_valid = 1'b1;
    @(negedge clk);
    t_acc = cyc;
    bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.bin = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 4 * STEPS) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), STEPS);
    for (int i = 0; i <= hold; i++) begin
      check("diff", bus.diff, ed);
      check("bout", 32'(bus.bout), 32'(eb));
      check("ltu", 32'(bus.ltu), 32'(eb));
      check("zero", 32'(bus.zero), 32'(ed == 0));
      check("lts", 32'(bus.lts), 32'(el));
      check("out_valid_hold", 32'(bus.out_valid), 1);
      check("in_ready_done", 32'(bus.in_ready), 0);
      if (i < hold) begin
        bus.in_valid = 1'b1;
        bus.a = $urandom;
        bus.b = $urandom;
        @(negedge clk);
      end
    end
    got = bus.diff;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_drop", 32'(bus.out_valid), 0);
    check("in_ready_back", 32'(bus.in_ready), 1);
  endtask
  logic [31:0] da [8] = '{32'd5, 32'd3, 32'h80000000, 32'h7FFFFFFF, 32'h12345678, 32'h12345678, 32'd0, 32'hFFFFFFFF};
  logic [31:0] db [8] = '{32'd3, 32'd5, 32'h00000001, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 32'd0, 32'd0};
  logic        dc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] dd [8] = '{32'd2, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
  initial begin
    logic [31:0] got, ra, rb;
    int t0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_diff", bus.diff, 0);
    check("rst_flags", {27'd0, bus.bout, bus.zero, bus.ltu, bus.lts, 1'b0}, 0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      do_op(da[i], db[i], dc[i], i == 0 ? 10 : 0, got);
      check("directed_diff", got, dd[i]);
    end
    do_op(32'd100, 32'd1, 1'b0, 0, got);
    t0 = t_acc;
    do_op(32'd7, 32'd9, 1'b1, 0, got);
    check("period", 32'(t_acc - t0), STEPS + 2);
    bus.a = 32'hFFFFFFFF;
    bus.b = 32'd0;
    bus.bin = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_in_ready", 32'(bus.in_ready), 1);
    check("abort_out_valid", 32'(bus.out_valid), 0);
    check("abort_diff", bus.diff, 0);
    check("abort_flags", {28'd0, bus.bout, bus.zero, bus.ltu, bus.lts}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(32'd10, 32'd4, 1'b0, 0, got);
    check("post_abort_diff", got, 32'd6);
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      do_op(ra, rb, 1'($urandom), $urandom_range(0, 2), got);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
